// File: rtl/fetch_pkg.sv
// fetch_pkg: shared fetch-stage widths, NOP encoding and the IF/ID bundle.
package fetch_pkg;
    localparam int INSTR_W = 32;
    localparam int PC_W = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;
    typedef struct packed {
        logic valid;
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0] pc;
        logic [PC_W-1:0] pc4;
    } if_id_t;
endpackage

// File: rtl/instr_fetch_if_id_reg.sv
// if_id_reg: IF/ID pipeline register; squash beats hold and clears the bundle.
module if_id_reg
    import fetch_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   hold_i,
    input  logic   squash_i,
    input  if_id_t d_i,
    output if_id_t q_o
);
    if_id_t q_q;
    always_ff @(posedge clk) begin
        if (rst || squash_i) q_q <= '0;
        else if (!hold_i) q_q <= d_i;
    end
    assign q_o = q_q;
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC register, next-PC mux and IF/ID capture for the MIPS core.
// Define IFETCH_DELAY_SLOT_EN to keep the redirect-cycle word as a delay slot.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_target,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [INSTR_W-1:0] rom_data,
    output logic [PC_W-1:0]    pc_out,
    output logic               if_id_valid,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [PC_W-1:0]    if_id_pc,
    output logic [PC_W-1:0]    if_id_pc4,
    output logic               misalign_err,
    output logic [31:0]        fetch_count
);
    logic [PC_W-1:0] pc_q, pc_d, pc4;
    logic [31:0] cnt_q;
    logic err_q, latch, squash;
    if_id_t ifid_d, ifid_q;

    assign pc4 = pc_q + 32'd4;
    assign pc_d = redirect ? {redirect_target[31:2], 2'b00} : stall ? pc_q : pc4;
`ifdef IFETCH_DELAY_SLOT_EN
    assign squash = 1'b0;
    assign latch = redirect | ~stall;
`else
    assign squash = redirect;
    assign latch = ~redirect & ~stall;
`endif
    assign ifid_d = '{valid: 1'b1, instr: rom_data, pc: pc_q, pc4: pc4};

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            pc_q <= pc_d;
            cnt_q <= cnt_q + {31'b0, latch};
            err_q <= err_q | (redirect & |redirect_target[1:0]);
        end
    end

    if_id_reg u_if_id (
        .clk(clk),
        .rst(rst),
        .hold_i(~latch & ~squash),
        .squash_i(squash),
        .d_i(ifid_d),
        .q_o(ifid_q)
    );

    assign rom_addr = pc_q[ADDR_W+1:2];
    assign pc_out = pc_q;
    assign if_id_valid = ifid_q.valid;
    assign if_id_instr = ifid_q.instr;
    assign if_id_pc = ifid_q.pc;
    assign if_id_pc4 = ifid_q.pc4;
    assign misalign_err = err_q;
    assign fetch_count = cnt_q;
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed plan plus random stimulus against a behavioural fetch model.
module tb_instr_fetch;
    logic clk = 0, rst = 0, stall = 0, redirect = 0;
    logic [31:0] redirect_target = 0, rom_data, pc_out, if_id_instr, if_id_pc, if_id_pc4, fetch_count;
    logic [9:0] rom_addr;
    logic if_id_valid, misalign_err;
    int n_chk = 0, n_pass = 0;
    logic [31:0] m_pc, m_instr, m_ipc, m_ipc4, m_cnt;
    bit m_valid, m_err;

    instr_fetch dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_target(redirect_target), .rom_addr(rom_addr), .rom_data(rom_data),
        .pc_out(pc_out), .if_id_valid(if_id_valid), .if_id_instr(if_id_instr),
        .if_id_pc(if_id_pc), .if_id_pc4(if_id_pc4), .misalign_err(misalign_err),
        .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;
    assign rom_data = 32'h1000_0000 | {22'b0, rom_addr};

    function automatic logic [31:0] rom_of(input logic [31:0] pc);
        return 32'h1000_0000 | ((pc / 4) % 1024);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic latch_model();
        m_valid = 1;
        m_instr = rom_of(m_pc);
        m_ipc = m_pc;
        m_ipc4 = m_pc + 4;
        m_cnt = m_cnt + 1;
    endtask

    task automatic step(input bit r, input bit s, input bit rd, input logic [31:0] tgt);
        rst = r; stall = s; redirect = rd; redirect_target = tgt;
        if (r) begin
            m_pc = 0; m_valid = 0; m_instr = 0; m_ipc = 0; m_ipc4 = 0; m_cnt = 0; m_err = 0;
        end else if (rd) begin
            if (tgt % 4 != 0) m_err = 1;
`ifdef IFETCH_DELAY_SLOT_EN
            latch_model();
`else
            m_valid = 0;
`endif
            m_pc = tgt - (tgt % 4);
        end else if (!s) begin
            latch_model();
            m_pc = m_pc + 4;
        end
        @(posedge clk);
        #1;
        chk("pc_out", pc_out, m_pc);
        chk("rom_addr", {22'b0, rom_addr}, (m_pc / 4) % 1024);
        chk("valid", {31'b0, if_id_valid}, {31'b0, m_valid});
        if (m_valid || r) begin
            chk("instr", if_id_instr, m_instr);
            chk("if_pc", if_id_pc, m_ipc);
            chk("if_pc4", if_id_pc4, m_ipc4);
        end
        chk("misalign", {31'b0, misalign_err}, {31'b0, m_err});
        chk("count", fetch_count, m_cnt);
    endtask

    initial begin
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("reset_rom_addr", {22'b0, rom_addr}, 32'h0);
        step(0, 0, 0, 0);
        chk("first_instr", if_id_instr, 32'h1000_0000);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("pc_after3", pc_out, 32'h0C);
        chk("count_after3", fetch_count, 32'd3);
        step(0, 0, 0, 0);
        repeat (3) step(0, 1, 0, 0);
        chk("stall_pc", pc_out, 32'h10);
        step(0, 0, 0, 0);
        chk("resume_pc", pc_out, 32'h14);
        step(0, 0, 1, 32'h08);
        step(0, 0, 1, 32'h40);
        chk("redir_pc", pc_out, 32'h40);
        step(0, 1, 1, 32'h100);
        chk("redir_stall_pc", pc_out, 32'h100);
        step(0, 0, 1, 32'h42);
        chk("misalign_pc", pc_out, 32'h40);
        repeat (10) step(0, $urandom_range(0, 1), 0, 0);
        step(0, 0, 1, 32'hFFC);
        chk("wrap_rom_addr", {22'b0, rom_addr}, 32'h3FF);
        step(0, 0, 0, 0);
        chk("wrap_pc", pc_out, 32'h1000);
        step(0, 0, 1, 32'hFFFF_FFFC);
        step(0, 0, 0, 0);
        chk("wrap32_pc", pc_out, 32'h0);
        step(1, 1, 1, 32'h80);
        chk("rst_redir_valid", {31'b0, if_id_valid}, 32'h0);
        for (int i = 0; i < 400; i++) begin
            logic [31:0] t;
            t = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 | $urandom_range(0, 15) : $urandom;
            step($urandom_range(0, 49) == 0, $urandom_range(0, 9) < 3,
                 $urandom_range(0, 9) < 2, t);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
